// File: rtl/timer_alarm_scheduler.sv
// Alarm table sharing one 64-bit deadline comparator across N_SLOTS slots.
// A round-robin pointer tests one slot per clock against the external ns Timer.
module timer_alarm_scheduler #(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned SLOT_W  = 2
) (
    input  logic               nReset,
    input  logic               Clk,
    input  logic [63:0]        Timer,
    input  logic               Arm_Valid,
    output logic               Arm_Ready,
    input  logic [SLOT_W-1:0]  Arm_Slot,
    input  logic [63:0]        Arm_Time,
    input  logic               Arm_Cancel,
    output logic [N_SLOTS-1:0] Armed,
    output logic [N_SLOTS-1:0] Fire,
    output logic               Missed
);

    logic               pend_q;
    logic [SLOT_W-1:0]  pend_slot_q;
    logic [63:0]        pend_time_q;
    logic               pend_cancel_q;

    logic [63:0]        time_q [N_SLOTS];
    logic [N_SLOTS-1:0] armed_q, armed_d;
    logic [N_SLOTS-1:0] fire_q, fire_d;
    logic               missed_q, missed_d;
    logic [SLOT_W-1:0]  ptr_q, ptr_d;

    logic               accept;
    logic               wr_en;
    logic               wr_hits_scan;
    logic               due;
    logic [63:0]        scan_diff;
    logic [63:0]        miss_diff;

    assign Arm_Ready = !pend_q;
    assign accept    = Arm_Valid && !pend_q;

    // Out-of-range slots still complete the handshake but never touch the table.
    assign wr_en        = pend_q && (32'(pend_slot_q) < N_SLOTS);
    assign wr_hits_scan = wr_en && (pend_slot_q == ptr_q);

    // Modular differences keep the comparison correct across Timer wrap.
    assign scan_diff = Timer - time_q[ptr_q];
    assign miss_diff = Timer - pend_time_q;
    assign due       = armed_q[ptr_q] && !scan_diff[63];

    assign ptr_d = (ptr_q == SLOT_W'(N_SLOTS - 1)) ? '0 : ptr_q + SLOT_W'(1);

    always_comb begin
        armed_d  = armed_q;
        fire_d   = '0;
        missed_d = 1'b0;
        // A table write to the slot under scan wins; that scan result is dropped.
        if (due && !wr_hits_scan) begin
            fire_d[ptr_q]  = 1'b1;
            armed_d[ptr_q] = 1'b0;
        end
        if (wr_en) begin
            armed_d[pend_slot_q] = !pend_cancel_q;
            missed_d             = !pend_cancel_q && !miss_diff[63];
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pend_q        <= 1'b0;
            pend_slot_q   <= '0;
            pend_time_q   <= '0;
            pend_cancel_q <= 1'b0;
        end else begin
            pend_q <= accept;
            if (accept) begin
                pend_slot_q   <= Arm_Slot;
                pend_time_q   <= Arm_Time;
                pend_cancel_q <= Arm_Cancel;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < int'(N_SLOTS); i++) begin
                time_q[i] <= '0;
            end
        end else if (wr_en && !pend_cancel_q) begin
            time_q[pend_slot_q] <= pend_time_q;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            armed_q  <= '0;
            fire_q   <= '0;
            missed_q <= 1'b0;
            ptr_q    <= '0;
        end else begin
            armed_q  <= armed_d;
            fire_q   <= fire_d;
            missed_q <= missed_d;
            ptr_q    <= ptr_d;
        end
    end

    assign Armed  = armed_q;
    assign Fire   = fire_q;
    assign Missed = missed_q;

endmodule
